// File: rtl/amba_spi_pkg.sv
// rtl/amba_spi_pkg.sv - shared constants for the APB-to-SPI slave wrapper
package amba_spi_pkg;

  localparam int FRAME_W = 10;
  localparam int TX_W    = 8;
  localparam int CNT_W   = 4;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_RXDATA = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_RX_OVR   = 3;

endpackage

// File: rtl/amba_spi_wrapper_if.sv
// rtl/amba_spi_wrapper_if.sv - APB register bus bundle with master/slave views
interface amba_spi_wrapper_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - PCLK-synchronous SPI slave shifters and frame counter
module spi_slave_core
  import amba_spi_pkg::*;
(
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               en,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [TX_W-1:0]    tx_load,
  output logic               MISO,
  output logic               frame_done,
  output logic               first_bit,
  output logic [FRAME_W-1:0] frame_data
);

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] rx_shift;
  logic [TX_W-1:0]    tx_shift;
  logic               active;

  assign active     = en & ~SS_n;
  assign frame_done = active & (bit_cnt == CNT_W'(FRAME_W - 1));
  assign first_bit  = active & (bit_cnt == '0);
  assign frame_data = {rx_shift, MOSI};
  assign MISO       = active & tx_shift[TX_W-1];

  // Reloading on the wrap edge lets frames run back-to-back without an SS_n gap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (!active) begin
      bit_cnt  <= '0;
      tx_shift <= tx_load;
    end else begin
      rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
      if (frame_done) begin
        bit_cnt  <= '0;
        tx_shift <= tx_load;
      end else begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        tx_shift <= {tx_shift[TX_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/amba_spi_wrapper.sv
// rtl/amba_spi_wrapper.sv - APB register map in front of a PCLK-synchronous SPI slave
module amba_spi_wrapper
  import amba_spi_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESETn,
  amba_spi_wrapper_if.slave   apb,
  input  logic                APB_MODE,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO
);

  logic               ctrl_en;
  logic [TX_W-1:0]    txdata;
  logic [FRAME_W-1:0] rxdata;
  logic               rx_valid;
  logic               tx_empty;
  logic               rx_ovr;

  logic               access;
  logic               mapped;
  logic               ro_hit;
  logic               wr_en;
  logic               rd_clr;
  logic               frame_done;
  logic               first_bit;
  logic [FRAME_W-1:0] frame_data;
  logic [TX_W-1:0]    tx_load;
  logic [3:0]         status;

  assign access = apb.PSEL & apb.PENABLE;
  assign mapped = (apb.PADDR == ADDR_CTRL)   | (apb.PADDR == ADDR_STATUS) |
                  (apb.PADDR == ADDR_RXDATA) | (apb.PADDR == ADDR_TXDATA);
  assign ro_hit = (apb.PADDR == ADDR_STATUS) | (apb.PADDR == ADDR_RXDATA);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (~mapped | (apb.PWRITE & ro_hit));
  assign wr_en       = access & apb.PWRITE & ~apb.PSLVERR;
  assign rd_clr      = access & ~apb.PWRITE & (apb.PADDR == ADDR_RXDATA);

  always_comb begin
    status              = '0;
    status[ST_RX_VALID] = rx_valid;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_BUSY]     = ctrl_en & ~SS_n;
    status[ST_RX_OVR]   = rx_ovr;
  end

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (apb.PADDR)
        ADDR_CTRL:   apb.PRDATA = {15'b0, ctrl_en};
        ADDR_STATUS: apb.PRDATA = {12'b0, status};
        ADDR_RXDATA: apb.PRDATA = {{(16-FRAME_W){1'b0}}, rxdata};
        ADDR_TXDATA: apb.PRDATA = {{(16-TX_W){1'b0}}, txdata};
        default:     apb.PRDATA = '0;
      endcase
    end
  end

  assign tx_load = APB_MODE ? txdata : rxdata[TX_W-1:0];

  spi_slave_core u_core (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .en         (ctrl_en),
    .SS_n       (SS_n),
    .MOSI       (MOSI),
    .tx_load    (tx_load),
    .MISO       (MISO),
    .frame_done (frame_done),
    .first_bit  (first_bit),
    .frame_data (frame_data)
  );

  // A frame landing on the RXDATA-read edge wins over the read-clear of RX_VALID.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_en  <= 1'b1;
      txdata   <= '0;
      rxdata   <= '0;
      rx_valid <= 1'b0;
      tx_empty <= 1'b1;
      rx_ovr   <= 1'b0;
    end else begin
      if (wr_en && apb.PADDR == ADDR_CTRL)
        ctrl_en <= apb.PWDATA[0];
      if (wr_en && apb.PADDR == ADDR_TXDATA)
        txdata <= apb.PWDATA;
      if (rd_clr) begin
        rx_valid <= 1'b0;
        rx_ovr   <= 1'b0;
      end
      if (frame_done) begin
        rxdata   <= frame_data;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_clr)
          rx_ovr <= 1'b1;
      end
      if (wr_en && apb.PADDR == ADDR_TXDATA)
        tx_empty <= 1'b0;
      else if (first_bit && APB_MODE)
        tx_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_amba_spi_wrapper.sv
// tb/tb_amba_spi_wrapper.sv - directed and random checks of amba_spi_wrapper against a register-level model
module tb_amba_spi_wrapper;

  logic PCLK;
  logic PRESETn;
  logic APB_MODE;
  logic SS_n;
  logic MOSI;
  logic MISO;

  amba_spi_wrapper_if bus ();

  amba_spi_wrapper dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (bus),
    .APB_MODE (APB_MODE),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural register image
  logic       m_en;
  logic [7:0] m_tx;
  logic [9:0] m_rx;
  logic       m_rxv;
  logic       m_txe;
  logic       m_ovr;

  task automatic model_reset();
    m_en = 1'b1; m_tx = '0; m_rx = '0; m_rxv = 1'b0; m_txe = 1'b1; m_ovr = 1'b0;
  endtask

  function automatic logic [15:0] model_reg(input logic [7:0] a);
    case (a)
      8'h00:   return {15'b0, m_en};
      8'h04:   return {12'b0, m_ovr, 1'b0, m_txe, m_rxv};
      8'h08:   return {6'b0, m_rx};
      8'h0C:   return {8'b0, m_tx};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return (a == 8'h00) || (a == 8'h04) || (a == 8'h08) || (a == 8'h0C);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_read(input logic [7:0] a);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1;
    chk($sformatf("rd_data[%0h]", a), bus.PRDATA, model_reg(a));
    chk($sformatf("rd_err[%0h]", a), {15'b0, bus.PSLVERR}, {15'b0, !is_mapped(a)});
    chk("rd_ready", {15'b0, bus.PREADY}, 16'h0001);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    if (a == 8'h08) begin
      m_rxv = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    logic err;
    err = !is_mapped(a) || (a == 8'h04) || (a == 8'h08);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1;
    chk($sformatf("wr_err[%0h]", a), {15'b0, bus.PSLVERR}, {15'b0, err});
    chk("wr_ready", {15'b0, bus.PREADY}, 16'h0001);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    if (!err) begin
      if (a == 8'h00) m_en = d[0];
      if (a == 8'h0C) begin m_tx = d; m_txe = 1'b0; end
    end
  endtask

  // Sends the first nbits of val MSB-first, then deasserts SS_n for one edge.
  task automatic send_frame(input logic [9:0] val, input int nbits);
    logic [7:0] word;
    logic       exp_bit;
    word = m_en ? (APB_MODE ? m_tx : m_rx[7:0]) : 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(posedge PCLK); #1;
      SS_n = 1'b0; MOSI = val[9-i];
      exp_bit = (m_en && i < 8) ? word[7-i] : 1'b0;
      #1;
      chk($sformatf("miso[%0d]", i), {15'b0, MISO}, {15'b0, exp_bit});
    end
    @(posedge PCLK); #1;
    SS_n = 1'b1; MOSI = 1'b0;
    if (m_en) begin
      if (nbits > 0 && APB_MODE) m_txe = 1'b1;
      if (nbits == 10) begin
        m_ovr = m_ovr | m_rxv;
        m_rxv = 1'b1;
        m_rx  = val;
      end
    end
  endtask

  initial begin
    PRESETn = 1'b0; APB_MODE = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    model_reset();
    #1;
    chk("rst_miso", {15'b0, MISO}, 16'h0000);
    chk("rst_pready", {15'b0, bus.PREADY}, 16'h0001);
    chk("rst_pslverr", {15'b0, bus.PSLVERR}, 16'h0000);
    chk("rst_prdata", bus.PRDATA, 16'h0000);
    #99 PRESETn = 1'b1;

    apb_read(8'h00);
    apb_read(8'h04);

    // TX write then the documented frame
    APB_MODE = 1'b1;
    apb_write(8'h0C, 8'hA5);
    apb_read(8'h04);
    apb_read(8'h08);
    apb_read(8'h0C);
    send_frame(10'b1011001110, 10);
    apb_read(8'h04);
    chk("frame_rx_model", {6'b0, m_rx}, 16'h02CE);
    apb_read(8'h08);
    apb_read(8'h04);

    // Overrun, then loopback of the last frame
    send_frame(10'($urandom_range(0, 1023)), 10);
    send_frame(10'($urandom_range(0, 1023)), 10);
    apb_read(8'h04);
    APB_MODE = 1'b0;
    send_frame(10'($urandom_range(0, 1023)), 10);
    apb_read(8'h08);

    // Error accesses leave state untouched
    apb_write(8'h04, 8'hFF);
    apb_write(8'h08, 8'h3C);
    apb_write(8'h10, 8'h00);
    apb_read(8'h10);
    apb_read(8'h00);
    apb_read(8'h04);
    apb_read(8'h0C);

    // Abort after 5 bits, then a full frame
    APB_MODE = 1'b1;
    send_frame(10'h3FF, 5);
    apb_read(8'h04);
    send_frame(10'h1B4, 10);
    apb_read(8'h04);
    apb_read(8'h08);

    // Disabled core: MISO quiet, no status movement
    apb_write(8'h00, 8'h00);
    apb_read(8'h00);
    send_frame(10'h155, 10);
    apb_read(8'h04);
    apb_read(8'h08);
    apb_write(8'h00, 8'h01);

    for (int k = 0; k < 8; k++) begin
      APB_MODE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) apb_write(8'h0C, 8'($urandom_range(0, 255)));
      send_frame(10'($urandom_range(0, 1023)), 10);
      apb_read(8'h04);
      if ($urandom_range(0, 1) == 1) apb_read(8'h08);
    end

    // Reset mid-frame
    APB_MODE = 1'b1;
    apb_write(8'h0C, 8'hFF);
    @(posedge PCLK); #1;
    SS_n = 1'b0; MOSI = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    chk("pre_rst_miso", {15'b0, MISO}, 16'h0001);
    PRESETn = 1'b0; SS_n = 1'b1;
    model_reset();
    #1;
    chk("midrst_miso", {15'b0, MISO}, 16'h0000);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h04;
    #1 chk("midrst_status", bus.PRDATA, 16'h0002);
    bus.PADDR = 8'h00;
    #1 chk("midrst_ctrl", bus.PRDATA, 16'h0001);
    bus.PADDR = 8'h0C;
    #1 chk("midrst_tx", bus.PRDATA, 16'h0000);
    bus.PSEL = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    send_frame(10'h2A7, 10);
    apb_read(8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
